// File: rtl/shifter_pkg.sv
// Shared definitions for the single-bit shift/rotate unit.
package shifter_pkg;

   typedef enum logic [2:0] {
      SLL0 = 3'b000,
      SLL1 = 3'b001,
      SRL0 = 3'b010,
      SRL1 = 3'b011,
      SLA  = 3'b100,
      SRA  = 3'b101,
      ROL  = 3'b110,
      ROR  = 3'b111
   } shift_mode_t;

endpackage

// File: rtl/shifter_core.sv
// Combinational mode mux: one-position shift or rotate of a, selected by m.
module shifter_core
   import shifter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [2:0]       m,
   output logic [WIDTH-1:0] r_next
);

   always_comb begin
      // NOTE: default first so every path assigns r_next; no latch is inferred.
      r_next = '0;
      unique case (shift_mode_t'(m))
         SLL0: r_next = {a[WIDTH-2:0], 1'b0};
         SLL1: r_next = {a[WIDTH-2:0], 1'b1};
         SRL0: r_next = {1'b0, a[WIDTH-1:1]};
         SRL1: r_next = {1'b1, a[WIDTH-1:1]};
         // Sign bit stays put; the bit just below it is shifted out.
         SLA:  r_next = {a[WIDTH-1], a[WIDTH-3:0], 1'b0};
         SRA:  r_next = {a[WIDTH-1], a[WIDTH-1:1]};
         ROL:  r_next = {a[WIDTH-2:0], a[WIDTH-1]};
         ROR:  r_next = {a[0], a[WIDTH-1:1]};
         default: r_next = '0;
      endcase
   end

endmodule

// File: rtl/shifter.sv
// Registered shift/rotate unit: one-cycle latency, result held while idle.
module shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [2:0]       m,
   output logic             out_valid,
   output logic [WIDTH-1:0] r
);

   logic [WIDTH-1:0] r_next;

   shifter_core #(.WIDTH(WIDTH)) u_core (
      .a      (a),
      .m      (m),
      .r_next (r_next)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         r         <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         // r only loads on a captured operation, so idle cycles never expose a/m.
         if (in_valid) r <= r_next;
      end
   end

endmodule

// File: tb/tb_shifter.sv
// Scoreboard bench for shifter: directed vectors, idle hold, random traffic, mid-stream reset.
module tb_shifter;

   localparam int W = 4;
   localparam int M = 1 << W;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] a;
   logic [2:0]   m;
   logic         out_valid;
   logic [W-1:0] r;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];

   shifter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .m         (m),
      .out_valid (out_valid),
      .r         (r)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model in plain integer arithmetic on the operand value.
   function automatic int model(input int av, input int mv);
      int msb, lsb, dbl, half;
      msb  = (av >= M/2) ? M/2 : 0;
      lsb  = av % 2;
      dbl  = (av * 2) % M;
      half = av / 2;
      case (mv)
         0: return dbl;
         1: return dbl + 1;
         2: return half;
         3: return half + M/2;
         4: return msb + ((av * 2) % (M/2));
         5: return half + msb;
         6: return dbl + (msb != 0 ? 1 : 0);
         default: return half + lsb * (M/2);
      endcase
   endfunction

   // Directed vectors with hand-derived expected results.
   typedef struct {
      logic [2:0]   mode;
      logic [W-1:0] op;
      logic [W-1:0] res;
   } vec_t;

   vec_t vecs[24] = '{
      '{3'b000, 4'b1111, 4'b1110}, '{3'b000, 4'b1010, 4'b0100}, '{3'b000, 4'b0111, 4'b1110},
      '{3'b001, 4'b1111, 4'b1111}, '{3'b001, 4'b1010, 4'b0101}, '{3'b001, 4'b0111, 4'b1111},
      '{3'b100, 4'b1001, 4'b1010}, '{3'b100, 4'b1010, 4'b1100}, '{3'b100, 4'b0111, 4'b0110},
      '{3'b010, 4'b1001, 4'b0100}, '{3'b010, 4'b1010, 4'b0101}, '{3'b010, 4'b0111, 4'b0011},
      '{3'b011, 4'b1001, 4'b1100}, '{3'b011, 4'b1010, 4'b1101}, '{3'b011, 4'b0111, 4'b1011},
      '{3'b101, 4'b1001, 4'b1100}, '{3'b101, 4'b1010, 4'b1101}, '{3'b101, 4'b0111, 4'b0011},
      '{3'b110, 4'b1001, 4'b0011}, '{3'b110, 4'b1010, 4'b0101}, '{3'b110, 4'b0111, 4'b1110},
      '{3'b111, 4'b1001, 4'b1100}, '{3'b111, 4'b1010, 4'b0101}, '{3'b111, 4'b0111, 4'b1011}
   };

   // Monitor: every presented result must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", 1, 0);
            end else begin
               check("result", int'(r), int'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic issue(input logic [2:0] mv, input logic [W-1:0] av, input logic [W-1:0] ev);
      in_valid = 1'b1;
      m        = mv;
      a        = av;
      exp_q.push_back(ev);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      a        = W'($urandom_range(M - 1));
      m        = 3'($urandom_range(7));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] av;
      logic [2:0]   mv;

      // Reset dominates an active in_valid.
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 4'b1111;
      m        = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      check("reset_r", int'(r), 0);
      check("reset_out_valid", int'(out_valid), 0);

      rst = 1'b0;
      idle();
      check("post_reset_idle_out_valid", int'(out_valid), 0);
      check("post_reset_idle_r", int'(r), 0);

      // Directed vectors back-to-back, then three idle cycles.
      foreach (vecs[i]) issue(vecs[i].mode, vecs[i].op, vecs[i].res);
      for (int k = 0; k < 3; k++) begin
         idle();
         check("idle_out_valid", int'(out_valid), 0);
         check("idle_hold_r", int'(r), 4'b1011);
      end
      check("directed_drained", exp_q.size(), 0);

      // Random traffic with random gaps, expectations from the model.
      for (int k = 0; k < 200; k++) begin
         if ($urandom_range(3) == 0) begin
            idle();
         end else begin
            av = W'($urandom_range(M - 1));
            mv = 3'($urandom_range(7));
            issue(mv, av, W'(model(int'(av), int'(mv))));
         end
      end

      // Mid-stream reset: last issued result is consumed, then reset wins over in_valid.
      issue(3'b110, 4'b1001, 4'b0011);
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 4'b0111;
      m        = 3'b001;
      @(posedge clk);
      #1;
      check("midreset_r", int'(r), 0);
      check("midreset_out_valid", int'(out_valid), 0);

      rst = 1'b0;
      issue(3'b101, 4'b1010, W'(model(10, 5)));
      repeat (3) idle();
      check("final_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
